seg_scan_display: RTL and testbench

Parametrised multiplexed seven-segment display driver, successor to the fixed 4-digit scanner. It time-multiplexes up to `DIGITS` hex digits onto shared segment lines, with per-digit decimal points and 16-level PWM brightness. Display contents are double-buffered so updates land only on frame boundaries. It sits between the calculator core (result/operand registers) and the board's common/segment pins.

---
 rtl/seg_pkg.sv | 17 +
 rtl/seg7_decode.sv | 15 +
 rtl/seg_scan_display.sv | 181 ++++++++++++++++++
 tb/tb_seg_scan_display.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low segment table,
// blank pattern and PWM resolution.
package seg_pkg;

  localparam int unsigned PWM_W = 4;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low a..g patterns, index = hex value
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble plus decimal point to active-low {a..g, dp} segment pattern.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] pattern
);

  // Table lookup; dp segment is active-low like the others
  always_comb begin
    pattern = {SEG_TABLE[nibble], ~dp};
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with PWM brightness and frame-aligned
// double buffering. Optional leading-zero blanking: define SEG_LZ_BLANK_EN.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned CLK_HZ  = 25000000,
  parameter int unsigned SCAN_HZ = 1000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [4*DIGITS-1:0]         digits_in,
  input  logic [DIGITS-1:0]           dp_in,
  input  logic [$clog2(DIGITS+1)-1:0] n,
  input  logic [PWM_W-1:0]            brightness,
  output logic [DIGITS-1:0]           com,
  output logic [7:0]                  seg,
  output logic                        frame
);

  localparam int unsigned DIV = CLK_HZ / (SCAN_HZ * (2 ** PWM_W));
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned NW  = $clog2(DIGITS + 1);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [NW-1:0] NMAX = NW'(DIGITS);

  generate
    if (DIV < 1) begin : g_div_check
      $error("seg_scan_display: CLK_HZ too low for SCAN_HZ");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_digits_check
      $error("seg_scan_display: DIGITS must be 1..8");
    end
  endgenerate

  logic [PW-1:0]       presc;
  logic                sub_tick;
  logic [PWM_W-1:0]    pwm;
  logic [IW-1:0]       idx;
  logic                slot_end;
  logic                boundary;
  logic                upd;

  logic [4*DIGITS-1:0] act_dig, sh_dig;
  logic [DIGITS-1:0]   act_dp, sh_dp;
  logic [NW-1:0]       n_act, sh_n, n_cl, next_n;
  logic                pending;

  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic [7:0]          cur_pat;
  logic                blank;
  logic                lit;
  logic [IW-1:0]       com_pos;
  logic [DIGITS-1:0]   com_next;
  logic [7:0]          seg_next;

  function automatic logic [IW-1:0] first_of(input logic [NW-1:0] cnt);
    return (cnt == '0) ? '0 : IW'(DIGITS - 32'(cnt));
  endfunction

  // Sub-tick prescaler and slot/frame boundary detection
  always_comb begin
    sub_tick = (presc == PW'(DIV - 1));
    slot_end = sub_tick && (pwm == '1);
    boundary = slot_end && ((n_act == '0) || (idx == LAST));
    n_cl     = (n > NMAX) ? NMAX : n;
    next_n   = load ? n_cl : (pending ? sh_n : n_act);
  end

  // Prescaler counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) presc <= '0;
    else if (sub_tick) presc <= '0;
    else presc <= presc + PW'(1);
  end

  // PWM phase and scan index; the index restarts on the new active range at a frame boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm <= '0;
      idx <= '0;
    end else if (sub_tick) begin
      pwm <= pwm + PWM_W'(1);
      if (boundary) idx <= first_of(next_n);
      else if (slot_end) idx <= idx + IW'(1);
    end
  end

  // Shadow/active buffers; a load on the boundary bypasses the shadow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_dig <= '0;
      act_dp  <= '0;
      n_act   <= '0;
      sh_dig  <= '0;
      sh_dp   <= '0;
      sh_n    <= '0;
      pending <= 1'b0;
    end else if (boundary) begin
      if (load) begin
        act_dig <= digits_in;
        act_dp  <= dp_in;
        n_act   <= n_cl;
      end else if (pending) begin
        act_dig <= sh_dig;
        act_dp  <= sh_dp;
        n_act   <= sh_n;
      end
      pending <= 1'b0;
    end else if (load) begin
      sh_dig  <= digits_in;
      sh_dp   <= dp_in;
      sh_n    <= n_cl;
      pending <= 1'b1;
    end
  end

  // Select the digit under the scan index
  always_comb begin
    cur_nib = act_dig[{idx, 2'b00} +: 4];
    cur_dp  = act_dp[idx];
  end

  seg7_decode u_dec (
    .nibble  (cur_nib),
    .dp      (cur_dp),
    .pattern (cur_pat)
  );

`ifdef SEG_LZ_BLANK_EN
  logic zero_run;

  // Blank a zero digit while every active digit up to and including it is zero
  always_comb begin
    zero_run = 1'b1;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      if ((j + 32'(n_act) >= DIGITS) && (j <= 32'(idx)) && (act_dig[4*j +: 4] != 4'h0))
        zero_run = 1'b0;
    end
    blank = zero_run && !cur_dp && (idx != LAST);
  end
`else
  // All active digits are shown
  always_comb begin
    blank = 1'b0;
  end
`endif

  // Next output pattern: one-hot common (digit 0 on the MSB) or dark
  always_comb begin
    lit      = (n_act != '0) && (pwm <= brightness) && !blank;
    com_pos  = LAST - idx;
    com_next = '0;
    seg_next = SEG_OFF;
    if (lit) begin
      com_next[com_pos] = 1'b1;
      seg_next          = cur_pat;
    end
  end

  // Registered outputs, updated one clock after each sub-tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd   <= 1'b0;
      com   <= '0;
      seg   <= SEG_OFF;
      frame <= 1'b0;
    end else begin
      upd   <= sub_tick;
      frame <= boundary;
      if (upd) begin
        com <= com_next;
        seg <= seg_next;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display (DIGITS=4, one clock per sub-tick).
module tb_seg_scan_display;

  localparam int unsigned DIGITS = 4;

  typedef struct {
    logic [3:0] com;
    logic [7:0] seg;
    logic       frame;
  } exp_t;

  localparam logic [6:0] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [2:0]  n = '0;
  logic [3:0]  brightness = 4'hF;
  logic [3:0]  com;
  logic [7:0]  seg;
  logic        frame;

  int checks = 0;
  int errors = 0;

  exp_t sbq[$];

  // Reference model state: displayed content, shadow copy, position in frame
  logic [3:0]  m_dig [DIGITS];
  logic [3:0]  s_dig [DIGITS];
  logic [3:0]  m_dp, s_dp;
  int unsigned m_n, s_n, m_pos, m_len;
  bit          m_pend;

  seg_scan_display #(.DIGITS(4), .CLK_HZ(1600), .SCAN_HZ(100)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .n          (n),
    .brightness (brightness),
    .com        (com),
    .seg        (seg),
    .frame      (frame)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endfunction

  // What the display should show for the frame position held in the model
  function automatic exp_t show();
    exp_t e;
    int unsigned slot, ph, d;
    bit blank;
    e.com = '0;
    e.seg = 8'hFF;
    e.frame = 1'b0;
    if (m_n == 0) return e;
    slot = m_pos / 16;
    ph   = m_pos % 16;
    d    = DIGITS - m_n + slot;
    if (ph > 32'(brightness)) return e;
    blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
    blank = (d != DIGITS - 1) && !m_dp[d];
    for (int unsigned j = DIGITS - m_n; j <= d; j++)
      if (m_dig[j] != 4'h0) blank = 1'b0;
`endif
    if (blank) return e;
    e.com = 4'(1 << (DIGITS - 1 - d));
    e.seg = {HEX[m_dig[d]], ~m_dp[d]};
    return e;
  endfunction

  // Reference model: advances one clock per edge and predicts the next output sample
  always @(posedge clk or posedge reset) begin
    exp_t e;
    bit bnd;
    int unsigned nn;
    if (reset) begin
      for (int i = 0; i < DIGITS; i++) begin
        m_dig[i] = 4'h0;
        s_dig[i] = 4'h0;
      end
      m_dp = '0; s_dp = '0;
      m_n = 0; s_n = 0;
      m_pos = 0; m_len = 16;
      m_pend = 1'b0;
      sbq.delete();
    end else begin
      e = show();
      nn = (n > 3'd4) ? 4 : 32'(n);
      m_pos++;
      bnd = (m_pos == m_len);
      if (bnd) begin
        if (load) begin
          for (int i = 0; i < DIGITS; i++) m_dig[i] = digits_in[4*i +: 4];
          m_dp = dp_in;
          m_n  = nn;
        end else if (m_pend) begin
          for (int i = 0; i < DIGITS; i++) m_dig[i] = s_dig[i];
          m_dp = s_dp;
          m_n  = s_n;
        end
        m_pend = 1'b0;
        m_pos  = 0;
        m_len  = ((m_n == 0) ? 1 : m_n) * 16;
      end else if (load) begin
        for (int i = 0; i < DIGITS; i++) s_dig[i] = digits_in[4*i +: 4];
        s_dp   = dp_in;
        s_n    = nn;
        m_pend = 1'b1;
      end
      e.frame = bnd;
      sbq.push_back(e);
    end
  end

  // Monitor: reset values while reset is held, otherwise pop and compare
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("rst_com", 8'(com), 8'h00);
      check("rst_seg", seg, 8'hFF);
      check("rst_frame", 8'(frame), 8'h00);
    end else if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check("com", 8'(com), 8'(e.com));
      check("seg", seg, e.seg);
      check("frame", 8'(frame), 8'(e.frame));
    end
  end

  task automatic tick(input int c);
    repeat (c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [2:0] nn);
    digits_in = d;
    dp_in     = dp;
    n         = nn;
    load      = 1'b1;
    tick(1);
    load      = 1'b0;
  endtask

  task automatic load_at_boundary(input logic [15:0] d, input logic [3:0] dp, input logic [2:0] nn);
    for (int i = 0; i < 200 && m_pos != m_len - 1; i++) tick(1);
    do_load(d, dp, nn);
  endtask

  initial begin
    #1 reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(200);

    // Full 4-digit display "1234"
    do_load(16'h4321, 4'h0, 3'd4);
    tick(150);
    // Two active digits "A5", then an oversized count
    do_load(16'h5A00, 4'h0, 3'd2);
    tick(100);
    do_load(16'hC0DE, 4'h5, 3'd7);
    tick(150);
    // Reduced duty
    brightness = 4'd3;
    tick(100);
    brightness = 4'd15;
    // Double load mid-frame: last one wins
    tick(10);
    do_load(16'h1111, 4'h0, 3'd4);
    tick(5);
    do_load(16'h9876, 4'h2, 3'd3);
    tick(150);
    // Load landing exactly on a boundary
    load_at_boundary(16'hBEEF, 4'h8, 3'd4);
    tick(80);
    // Leading zeros, all zeros, zero with dp
    do_load(16'h0700, 4'h0, 3'd4);
    tick(150);
    do_load(16'h0000, 4'h0, 3'd4);
    tick(150);
    do_load(16'h0000, 4'h2, 3'd4);
    tick(150);
    // Reset with a load pending
    do_load(16'h1234, 4'hF, 3'd4);
    tick(3);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(100);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        logic [15:0] d;
        d = 16'($urandom);
        if ($urandom_range(0, 1) == 1) d = d & 16'($urandom);
        do_load(d, 4'($urandom), 3'($urandom_range(0, 7)));
      end else if ($urandom_range(0, 99) == 0) begin
        brightness = 4'($urandom);
        tick(1);
      end else begin
        tick(1);
      end
    end
    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
